// File: rtl/pc_sequencer_if.sv
// Bus between the control unit and the program-counter sequencer: next-PC
// controls and operands in, architectural PC, previews and status flags out.
interface pc_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             pc_we;
  logic [2:0]       sel;
  logic             br_taken;
  logic [15:0]      imm16;
  logic [25:0]      target26;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] epc;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus;
  logic [WIDTH-1:0] npc;
  logic             misalign;
  logic             wrap;

  modport master (
    output pc_we, sel, br_taken, imm16, target26, rs_val, epc,
    input  pc, pc_plus, npc, misalign, wrap
  );

  modport slave (
    input  pc_we, sel, br_taken, imm16, target26, rs_val, epc,
    output pc, pc_plus, npc, misalign, wrap
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter for the multi-cycle CPU: selects next-PC from sequential,
// branch, jump, register-jump, exception and return sources; flags bad targets.
module pc_sequencer #(
  parameter int               WIDTH      = 32,
  parameter int unsigned      STEP       = 4,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(32'h0040_0000),
  parameter logic [WIDTH-1:0] EXC_VEC    = WIDTH'(32'h0040_0004),
  parameter int               ALIGN_BITS = 2
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.slave  bus
);

  localparam logic [2:0] SEL_SEQ  = 3'd0;
  localparam logic [2:0] SEL_BR   = 3'd1;
  localparam logic [2:0] SEL_J    = 3'd2;
  localparam logic [2:0] SEL_JR   = 3'd3;
  localparam logic [2:0] SEL_EXC  = 3'd4;
  localparam logic [2:0] SEL_ERET = 3'd5;

  localparam logic [WIDTH:0]   STEP_W     = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  logic [WIDTH-1:0] pc_d, pc_q;
  logic             misalign_d, misalign_q;
  logic             wrap_d, wrap_q;

  logic [WIDTH:0]   inc_s;
  logic [WIDTH-1:0] pc_plus_s;
  logic             carry_s;
  logic [WIDTH-1:0] br_off_s;
  logic [WIDTH-1:0] br_target_s;
  logic [WIDTH-1:0] j_target_s;
  logic [WIDTH-1:0] npc_s;
  logic             checked_s;

  // One extra bit on the increment exposes the carry that drives wrap.
  assign inc_s       = {1'b0, pc_q} + STEP_W;
  assign pc_plus_s   = inc_s[WIDTH-1:0];
  assign carry_s     = inc_s[WIDTH];
  assign br_off_s    = WIDTH'({{WIDTH{bus.imm16[15]}}, bus.imm16, 2'b00});
  assign br_target_s = pc_plus_s + br_off_s;

  generate
    if (WIDTH > 28) begin : g_j_wide
      assign j_target_s = {pc_plus_s[WIDTH-1:28], bus.target26, 2'b00};
    end else begin : g_j_narrow
      assign j_target_s = WIDTH'({bus.target26, 2'b00});
    end
  endgenerate

  // Next-PC source multiplexer.
  always_comb begin
    npc_s = pc_q;
    case (bus.sel)
      SEL_SEQ:  npc_s = pc_plus_s;
      SEL_BR:   npc_s = bus.br_taken ? br_target_s : pc_plus_s;
      SEL_J:    npc_s = j_target_s;
      SEL_JR:   npc_s = bus.rs_val;
      SEL_EXC:  npc_s = EXC_VEC;
      SEL_ERET: npc_s = bus.epc;
      default:  npc_s = pc_q;
    endcase
  end

  // Commit decision: alignment check, sticky misalign and wrap pulse.
  always_comb begin
    pc_d       = pc_q;
    misalign_d = misalign_q;
    wrap_d     = 1'b0;
    checked_s  = 1'b0;
    case (bus.sel)
      SEL_BR:                   checked_s = bus.br_taken;
      SEL_J, SEL_JR, SEL_ERET:  checked_s = 1'b1;
      default:                  checked_s = 1'b0;
    endcase
    if (bus.pc_we) begin
      // ERET clears the flag first so a misaligned return target re-sets it.
      if (bus.sel == SEL_ERET) begin
        misalign_d = 1'b0;
      end else begin
        misalign_d = misalign_q;
      end
      if (checked_s && ((npc_s & ALIGN_MASK) != {WIDTH{1'b0}})) begin
        pc_d       = EXC_VEC;
        misalign_d = 1'b1;
      end else begin
        pc_d = npc_s;
      end
      if (bus.sel == SEL_SEQ) begin
        wrap_d = carry_s;
      end else begin
        wrap_d = 1'b0;
      end
    end else begin
      pc_d       = pc_q;
      misalign_d = misalign_q;
      wrap_d     = 1'b0;
    end
  end

  // State registers with synchronous active-low reset taking priority.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      wrap_q     <= wrap_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_plus  = pc_plus_s;
  assign bus.npc      = npc_s;
  assign bus.misalign = misalign_q;
  assign bus.wrap     = wrap_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: 32-bit and 16-bit/STEP=2 instances driven in lockstep,
// directed steps plus random traffic, both checked against an arithmetic model.
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pc_sequencer_if #(.WIDTH(32)) b32 ();
  pc_sequencer_if #(.WIDTH(16)) b16 ();

  pc_sequencer #(.WIDTH(32), .STEP(4), .RESET_PC(32'h0040_0000),
                 .EXC_VEC(32'h0040_0004), .ALIGN_BITS(2))
    dut32 (.clk(clk), .rst(rst), .bus(b32.slave));

  pc_sequencer #(.WIDTH(16), .STEP(2), .RESET_PC(16'h0100),
                 .EXC_VEC(16'h0004), .ALIGN_BITS(2))
    dut16 (.clk(clk), .rst(rst), .bus(b16.slave));

  // Model state, index 0 = 32-bit instance, index 1 = 16-bit instance.
  longint m_pc   [2];
  bit     m_mis  [2];
  bit     m_wrap [2];
  int     mw     [2] = '{32, 16};
  longint mstep  [2] = '{4, 2};
  longint mrst   [2] = '{64'h0040_0000, 64'h0100};
  longint mexc   [2] = '{64'h0040_0004, 64'h0004};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint wmask(int k);
    return (64'd1 << mw[k]) - 64'd1;
  endfunction

  function automatic longint ref_npc(int k, int s, bit br, logic [15:0] imm,
                                     longint tgt, longint rs, longint ep);
    longint p1;
    p1 = (m_pc[k] + mstep[k]) & wmask(k);
    case (s)
      0: return p1;
      1: return br ? ((p1 + longint'($signed(imm)) * 4) & wmask(k)) : p1;
      2: return (mw[k] > 28) ? (((p1 >> 28) << 28) | (tgt * 4)) : ((tgt * 4) & wmask(k));
      3: return rs & wmask(k);
      4: return mexc[k];
      5: return ep & wmask(k);
      default: return m_pc[k];
    endcase
  endfunction

  task automatic ref_step(int k, bit we, int s, bit br, logic [15:0] imm,
                          longint tgt, longint rs, longint ep, bit rv);
    longint n;
    bit     chk;
    n = ref_npc(k, s, br, imm, tgt, rs, ep);
    if (!rv) begin
      m_pc[k] = mrst[k]; m_mis[k] = 1'b0; m_wrap[k] = 1'b0;
    end else if (we) begin
      chk = (s == 1 && br) || s == 2 || s == 3 || s == 5;
      m_wrap[k] = (s == 0) && (m_pc[k] + mstep[k] > wmask(k));
      if (s == 5) m_mis[k] = 1'b0;
      if (chk && (n % 4 != 0)) begin
        m_pc[k] = mexc[k]; m_mis[k] = 1'b1;
      end else begin
        m_pc[k] = n;
      end
    end else begin
      m_wrap[k] = 1'b0;
    end
  endtask

  task automatic apply(input bit we, input logic [2:0] s, input bit br, input logic [15:0] imm,
                       input logic [25:0] tgt, input logic [31:0] rs, input logic [31:0] ep,
                       input bit rv);
    @(negedge clk);
    rst = rv;
    b32.pc_we = we; b32.sel = s; b32.br_taken = br; b32.imm16 = imm;
    b32.target26 = tgt; b32.rs_val = rs; b32.epc = ep;
    b16.pc_we = we; b16.sel = s; b16.br_taken = br; b16.imm16 = imm;
    b16.target26 = tgt; b16.rs_val = rs[15:0]; b16.epc = ep[15:0];
    #1;
    check("npc32", b32.npc, ref_npc(0, s, br, imm, tgt, rs, ep));
    check("pc_plus32", b32.pc_plus, (m_pc[0] + mstep[0]) & wmask(0));
    check("npc16", b16.npc, ref_npc(1, s, br, imm, tgt, rs, ep));
    check("pc_plus16", b16.pc_plus, (m_pc[1] + mstep[1]) & wmask(1));
    for (int k = 0; k < 2; k++) ref_step(k, we, s, br, imm, tgt, rs, ep, rv);
    @(posedge clk);
    #1;
    check("pc32", b32.pc, m_pc[0]);
    check("misalign32", b32.misalign, m_mis[0]);
    check("wrap32", b32.wrap, m_wrap[0]);
    check("pc16", b16.pc, m_pc[1]);
    check("misalign16", b16.misalign, m_mis[1]);
    check("wrap16", b16.wrap, m_wrap[1]);
  endtask

  initial begin
    logic [31:0] rs;
    rst = 1'b0;
    b32.pc_we = 1'b0; b32.sel = 3'd0; b32.br_taken = 1'b0; b32.imm16 = 16'h0;
    b32.target26 = 26'h0; b32.rs_val = 32'h0; b32.epc = 32'h0;
    b16.pc_we = 1'b0; b16.sel = 3'd0; b16.br_taken = 1'b0; b16.imm16 = 16'h0;
    b16.target26 = 26'h0; b16.rs_val = 16'h0; b16.epc = 16'h0;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = mrst[k]; m_mis[k] = 1'b0; m_wrap[k] = 1'b0;
    end

    // Reset wins over a pending JR commit.
    apply(1'b1, 3'd3, 1'b0, 16'h0, 26'h0, 32'h0000_1000, 32'h0, 1'b0);
    check("d_reset_pc32", b32.pc, 64'h0040_0000);
    check("d_reset_pc16", b16.pc, 64'h0100);
    check("d_reset_mis", b32.misalign, 64'h0);

    apply(1'b1, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b1);
    check("d_seq1", b32.pc, 64'h0040_0004);
    apply(1'b1, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b1);
    check("d_seq2", b32.pc, 64'h0040_0008);
    apply(1'b1, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b1);
    check("d_seq3", b32.pc, 64'h0040_000C);
    check("d_seq3_16", b16.pc, 64'h0106);
    check("d_seq3_wrap", b32.wrap, 64'h0);

    apply(1'b1, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b1);
    apply(1'b1, 3'd1, 1'b1, 16'hFFFE, 26'h0, 32'h0, 32'h0, 1'b1);
    check("d_br_taken", b32.pc, 64'h0040_000C);
    apply(1'b1, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b1);
    apply(1'b1, 3'd1, 1'b0, 16'hFFFE, 26'h0, 32'h0, 32'h0, 1'b1);
    check("d_br_not_taken", b32.pc, 64'h0040_0014);

    apply(1'b1, 3'd3, 1'b0, 16'h0, 26'h0, 32'h0040_0010, 32'h0, 1'b1);
    apply(1'b1, 3'd2, 1'b0, 16'h0, 26'h0100000, 32'h0, 32'h0, 1'b1);
    check("d_jump", b32.pc, 64'h0040_0000);
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b1);
      check("d_hold_we0", b32.pc, 64'h0040_0000);
    end

    apply(1'b1, 3'd3, 1'b0, 16'h0, 26'h0, 32'h0040_0022, 32'h0, 1'b1);
    check("d_jr_mis_pc", b32.pc, 64'h0040_0004);
    check("d_jr_mis_flag", b32.misalign, 64'h1);
    apply(1'b1, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b1);
    check("d_mis_sticky", b32.misalign, 64'h1);
    apply(1'b1, 3'd5, 1'b0, 16'h0, 26'h0, 32'h0, 32'h0040_0100, 1'b1);
    check("d_eret_pc", b32.pc, 64'h0040_0100);
    check("d_eret_clr", b32.misalign, 64'h0);
    apply(1'b1, 3'd5, 1'b0, 16'h0, 26'h0, 32'h0, 32'h0040_0102, 1'b1);
    check("d_eret_bad_pc", b32.pc, 64'h0040_0004);
    check("d_eret_bad_mis", b32.misalign, 64'h1);

    apply(1'b1, 3'd3, 1'b0, 16'h0, 26'h0, 32'hFFFF_FFFC, 32'h0, 1'b1);
    apply(1'b1, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b1);
    check("d_wrap_pc", b32.pc, 64'h0);
    check("d_wrap_pulse", b32.wrap, 64'h1);
    check("d_wrap16_pc", b16.pc, 64'hFFFE);
    apply(1'b1, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b1);
    check("d_wrap_once", b32.wrap, 64'h0);
    check("d_wrap16_pc2", b16.pc, 64'h0000);
    check("d_wrap16_pulse", b16.wrap, 64'h1);

    apply(1'b1, 3'd4, 1'b0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b1);
    check("d_exc", b32.pc, 64'h0040_0004);
    apply(1'b1, 3'd6, 1'b0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b1);
    check("d_hold_sel", b32.pc, 64'h0040_0004);
    apply(1'b1, 3'd3, 1'b0, 16'h0, 26'h0, 32'h0000_1000, 32'h0, 1'b0);
    check("d_reset_mid", b32.pc, 64'h0040_0000);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       rs = 32'hFFFF_FFFC;
        1:       rs = $urandom & 32'hFFFF_FFFC;
        2:       rs = $urandom;
        default: rs = 32'h0040_0000 + ($urandom_range(0, 255) << 2);
      endcase
      apply($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 1'($urandom),
            16'($urandom), 26'($urandom), rs,
            ($urandom_range(0, 1) != 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom,
            $urandom_range(0, 49) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
